// File: rtl/sam_trace_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sam_trace_pkg
// Purpose  : Shared types for the SAM trace buffer: FSM state encoding and
//            the trace-entry record stored in the FIFO.
// Config   : SAM_TRACE_TIMESTAMP_EN adds a 32-bit ts field to each entry.
// Revision : 1.0 - initial release
// ============================================================================
package sam_trace_pkg;

  // Widest PC / writeback value an entry can hold; the top zero-pads
  // narrower XLEN values into these fields.
  localparam int C_XLEN_MAX = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } trace_state_t;

  typedef struct packed {
    logic [C_XLEN_MAX-1:0] npc;
    logic [C_XLEN_MAX-1:0] wb;
`ifdef SAM_TRACE_TIMESTAMP_EN
    logic [31:0]           ts;
`endif
  } trace_entry_t;

endpackage : sam_trace_pkg
`default_nettype wire

// File: rtl/sam_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sam_trace_fifo
// Purpose  : DEPTH-entry FIFO of trace entries with occupancy count.
//            head is read straight from storage (no bypass from push_data).
// Ports    : clk, RN (async active-low reset), flush (clears pointers and
//            level, wins over push/pop), push/push_data, pop, head,
//            not_empty, drop (push refused because full), level.
// Revision : 1.0 - initial release
// ============================================================================
module sam_trace_fifo
  import sam_trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     RN,
  input  logic                     flush,
  input  logic                     push,
  input  trace_entry_t             push_data,
  input  logic                     pop,
  output trace_entry_t             head,
  output logic                     not_empty,
  output logic                     drop,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  trace_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;

  logic w_full;
  logic w_empty;
  logic w_do_pop;
  logic w_do_push;

  assign w_full    = (r_level == (AW+1)'(DEPTH));
  assign w_empty   = (r_level == '0);
  // A pop on an empty FIFO is ignored; a push into a full FIFO only
  // succeeds when a pop frees the head slot in the same cycle.
  assign w_do_pop  = pop && !w_empty;
  assign w_do_push = push && (!w_full || w_do_pop);

  always_ff @(posedge clk or negedge RN) begin
    if (!RN) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign head      = r_mem[r_rd_ptr];
  assign not_empty = !w_empty;
  assign drop      = push && !w_do_push;
  assign level     = r_level;

endmodule : sam_trace_fifo
`default_nettype wire

// File: rtl/sam_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module   : sam_trace_buffer
// Purpose  : Post-trigger trace capture of core next-PC / writeback values
//            into a FIFO, drained through a valid/ready read port.
// Ports    : clk, RN (async active-low reset), npc, wb_out, cap_en, arm,
//            trig, out_ready / out_valid, out_npc, out_wb, level, state,
//            ovf_cnt, out_ts (timestamp build only).
// Config   : SAM_TRACE_TIMESTAMP_EN adds a free-running 32-bit cycle
//            counter and the out_ts port.
// Revision : 1.0 - initial release
// ============================================================================
module sam_trace_buffer
  import sam_trace_pkg::*;
#(
  parameter int XLEN     = 32,   // must not exceed C_XLEN_MAX
  parameter int DEPTH    = 16,   // power of two, >= 2
  parameter int POST_CNT = 8,    // 1..255
  parameter int CHG_ONLY = 0
) (
  input  logic                   clk,
  input  logic                   RN,
  input  logic [XLEN-1:0]        npc,
  input  logic [XLEN-1:0]        wb_out,
  input  logic                   cap_en,
  input  logic                   arm,
  input  logic                   trig,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [XLEN-1:0]        out_npc,
  output logic [XLEN-1:0]        out_wb,
  output logic [$clog2(DEPTH):0] level,
  output logic [1:0]             state,
  output logic [7:0]             ovf_cnt
`ifdef SAM_TRACE_TIMESTAMP_EN
  ,
  output logic [31:0]            out_ts
`endif
);

  trace_state_t r_state;
  trace_state_t w_state_nxt;

  logic [7:0]      r_post;
  logic [7:0]      r_ovf;
  logic [XLEN-1:0] r_last_npc;
  logic            r_last_vld;

  logic         w_win;
  logic         w_pass;
  logic         w_sample;
  logic         w_pop;
  logic         w_post_hit;
  logic         w_drop;
  logic         w_not_empty;
  trace_entry_t w_entry;
  trace_entry_t w_head;

  // The sample being counted now is the last one of the post-trigger window.
  assign w_post_hit = (({1'b0, r_post} + 9'd1) == 9'(POST_CNT));

  // A repeated npc is filtered only once a previous sample has been seen
  // since reset/arm, so the first sample always passes.
  assign w_pass = (CHG_ONLY == 0) || !r_last_vld || (npc != r_last_npc);

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or negedge RN) begin
    if (!RN) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    w_state_nxt = r_state;
    if (arm) begin
      w_state_nxt = ST_ARMED;
    end else begin
      unique case (r_state)
        // With POST_CNT=1 the triggering sample alone completes the window.
        ST_ARMED: if (trig) w_state_nxt = (w_sample && w_post_hit) ? ST_DONE : ST_RUN;
        ST_RUN:   if (w_sample && w_post_hit) w_state_nxt = ST_DONE;
        default:  w_state_nxt = r_state;
      endcase
    end
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    w_win = 1'b0;
    unique case (r_state)
      ST_ARMED: w_win = trig;
      ST_RUN:   w_win = 1'b1;
      default:  w_win = 1'b0;
    endcase
    w_sample = w_win && cap_en && w_pass && !arm;
    w_pop    = out_ready && !arm;
  end

  // ---------------------------------------------------------------- counters
  always_ff @(posedge clk or negedge RN) begin
    if (!RN) begin
      r_post     <= '0;
      r_ovf      <= '0;
      r_last_npc <= '0;
      r_last_vld <= 1'b0;
    end else if (arm) begin
      r_post     <= '0;
      r_ovf      <= '0;
      r_last_vld <= 1'b0;
    end else begin
      // Dropped samples still advance the post-trigger count.
      if (w_sample) begin
        r_post     <= r_post + 8'd1;
        r_last_npc <= npc;
        r_last_vld <= 1'b1;
      end
      if (w_drop && (r_ovf != 8'hFF)) begin
        r_ovf <= r_ovf + 8'd1;
      end
    end
  end

`ifdef SAM_TRACE_TIMESTAMP_EN
  logic [31:0] r_cyc;

  always_ff @(posedge clk or negedge RN) begin
    if (!RN) begin
      r_cyc <= '0;
    end else begin
      r_cyc <= r_cyc + 32'd1;
    end
  end
`endif

  always_comb begin
    w_entry                 = '0;
    w_entry.npc[XLEN-1:0]   = npc;
    w_entry.wb[XLEN-1:0]    = wb_out;
`ifdef SAM_TRACE_TIMESTAMP_EN
    w_entry.ts              = r_cyc;
`endif
  end

  sam_trace_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .RN        (RN),
    .flush     (arm),
    .push      (w_sample),
    .push_data (w_entry),
    .pop       (w_pop),
    .head      (w_head),
    .not_empty (w_not_empty),
    .drop      (w_drop),
    .level     (level)
  );

  // Pad bits above XLEN carry no information.
  logic w_unused_pad;
  assign w_unused_pad = ^{w_head.npc, w_head.wb};

  assign out_valid = w_not_empty;
  assign out_npc   = w_head.npc[XLEN-1:0];
  assign out_wb    = w_head.wb[XLEN-1:0];
`ifdef SAM_TRACE_TIMESTAMP_EN
  assign out_ts    = w_head.ts;
`endif
  assign state     = r_state;
  assign ovf_cnt   = r_ovf;

endmodule : sam_trace_buffer
`default_nettype wire
